// File: rtl/idex_forward_pkg.sv
// rtl/idex_forward_pkg.sv - shared widths, ALU/forward encodings and latched-field layout
package idex_forward_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_MUL = 3'b101,
        ALU_SUB = 3'b110
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] rs1_addr;
        logic [ADDR_W-1:0] rs2_addr;
        logic [ADDR_W-1:0] rd_addr;
        logic              alu_src;
        logic [2:0]        alu_ctrl;
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_read;
        logic              mem_write;
    } idex_fields_t;

    // Younger EX/MEM result wins over MEM/WB; x0 is hardwired so it is never bypassed.
    function automatic fwd_sel_e fwd_select(
        input logic [ADDR_W-1:0] rs_addr,
        input logic              ex_we,
        input logic [ADDR_W-1:0] ex_rd,
        input logic              wb_we,
        input logic [ADDR_W-1:0] wb_rd
    );
        if (ex_we && (ex_rd != '0) && (ex_rd == rs_addr))
            return FWD_EXMEM;
        else if (wb_we && (wb_rd != '0) && (wb_rd == rs_addr))
            return FWD_MEMWB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/idex_forward_if.sv
// rtl/idex_forward_if.sv - EX/MEM and MEM/WB bypass bus into the ID/EX stage
interface idex_forward_if;
    import idex_forward_pkg::*;

    logic              exmem_RegWrite;
    logic [ADDR_W-1:0] exmem_RDaddr;
    logic [DATA_W-1:0] exmem_data;
    logic              memwb_RegWrite;
    logic [ADDR_W-1:0] memwb_RDaddr;
    logic [DATA_W-1:0] memwb_data;

    modport master (
        output exmem_RegWrite, exmem_RDaddr, exmem_data,
        output memwb_RegWrite, memwb_RDaddr, memwb_data
    );

    modport slave (
        input exmem_RegWrite, exmem_RDaddr, exmem_data,
        input memwb_RegWrite, memwb_RDaddr, memwb_data
    );
endinterface

// File: rtl/idex_forward_forward_unit.sv
// rtl/idex_forward_forward_unit.sv - combinational bypass select for both ALU source operands
module forward_unit
    import idex_forward_pkg::*;
(
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    input  logic              exmem_RegWrite_i,
    input  logic [ADDR_W-1:0] exmem_RDaddr_i,
    input  logic              memwb_RegWrite_i,
    input  logic [ADDR_W-1:0] memwb_RDaddr_i,
    output fwd_sel_e          fwd1_sel_o,
    output fwd_sel_e          fwd2_sel_o
);

    assign fwd1_sel_o = fwd_select(rs1_addr_i, exmem_RegWrite_i, exmem_RDaddr_i,
                                   memwb_RegWrite_i, memwb_RDaddr_i);
    assign fwd2_sel_o = fwd_select(rs2_addr_i, exmem_RegWrite_i, exmem_RDaddr_i,
                                   memwb_RegWrite_i, memwb_RDaddr_i);

endmodule

// File: rtl/idex_forward.sv
// rtl/idex_forward.sv - ID/EX pipeline register with operand bypass and load-use detect
module idex_forward
    import idex_forward_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] RS1data_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [ADDR_W-1:0] RS1addr_i,
    input  logic [ADDR_W-1:0] RS2addr_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    input  logic              ALUSrc_i,
    input  logic [2:0]        ALUCtrl_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    idex_forward_if.slave     byp,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic [2:0]        ALUCtrl_o,
    output logic [DATA_W-1:0] storedata_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic [ADDR_W-1:0] RDaddr_o,
    output logic              hazard_o
);

    idex_fields_t fields_q, fields_d, id_fields;
    fwd_sel_e     fwd1_sel, fwd2_sel;
    logic [DATA_W-1:0] rs1_fwd, rs2_fwd;

    assign id_fields = '{
        rs1_data:   RS1data_i,
        rs2_data:   RS2data_i,
        imm:        imm_i,
        rs1_addr:   RS1addr_i,
        rs2_addr:   RS2addr_i,
        rd_addr:    RDaddr_i,
        alu_src:    ALUSrc_i,
        alu_ctrl:   ALUCtrl_i,
        reg_write:  RegWrite_i,
        mem_to_reg: MemtoReg_i,
        mem_read:   MemRead_i,
        mem_write:  MemWrite_i
    };

    // Flush outranks stall so a held load-use victim is replaced by a bubble.
    always_comb begin
        fields_d = fields_q;
        if (flush_i)
            fields_d = '0;
        else if (!stall_i)
            fields_d = id_fields;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            fields_q <= '0;
        else
            fields_q <= fields_d;
    end

    forward_unit u_forward_unit (
        .rs1_addr_i       (fields_q.rs1_addr),
        .rs2_addr_i       (fields_q.rs2_addr),
        .exmem_RegWrite_i (byp.exmem_RegWrite),
        .exmem_RDaddr_i   (byp.exmem_RDaddr),
        .memwb_RegWrite_i (byp.memwb_RegWrite),
        .memwb_RDaddr_i   (byp.memwb_RDaddr),
        .fwd1_sel_o       (fwd1_sel),
        .fwd2_sel_o       (fwd2_sel)
    );

    always_comb begin
        rs1_fwd = fields_q.rs1_data;
        rs2_fwd = fields_q.rs2_data;
        case (fwd1_sel)
            FWD_EXMEM: rs1_fwd = byp.exmem_data;
            FWD_MEMWB: rs1_fwd = byp.memwb_data;
            default:   rs1_fwd = fields_q.rs1_data;
        endcase
        case (fwd2_sel)
            FWD_EXMEM: rs2_fwd = byp.exmem_data;
            FWD_MEMWB: rs2_fwd = byp.memwb_data;
            default:   rs2_fwd = fields_q.rs2_data;
        endcase
    end

    assign data1_o     = rs1_fwd;
    assign data2_o     = fields_q.alu_src ? fields_q.imm : rs2_fwd;
    assign storedata_o = rs2_fwd;
    assign ALUCtrl_o   = fields_q.alu_ctrl;
    assign RegWrite_o  = fields_q.reg_write;
    assign MemtoReg_o  = fields_q.mem_to_reg;
    assign MemRead_o   = fields_q.mem_read;
    assign MemWrite_o  = fields_q.mem_write;
    assign RDaddr_o    = fields_q.rd_addr;

    assign hazard_o = fields_q.mem_read && (fields_q.rd_addr != '0) &&
                      ((fields_q.rd_addr == RS1addr_i) || (fields_q.rd_addr == RS2addr_i));

endmodule

// File: tb/tb_idex_forward.sv
// tb/tb_idex_forward.sv - scoreboard bench for the ID/EX register and bypass front end
module tb_idex_forward;

    typedef struct {
        logic [31:0] rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rda;
        logic        alusrc;
        logic [2:0]  alu;
        logic [3:0]  ctrl;
    } id_t;

    typedef struct {
        logic        exw;
        logic [4:0]  exrd;
        logic [31:0] exd;
        logic        wbw;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
    } byp_t;

    typedef struct {
        string       name;
        logic [31:0] d1, d2, sd;
        logic [2:0]  alu;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        hz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rda;
    logic        alusrc, rw, m2r, mr, mw;
    logic [2:0]  aluc;
    logic [31:0] data1, data2, storedata;
    logic [2:0]  alu_o;
    logic        rw_o, m2r_o, mr_o, mw_o, hazard;
    logic [4:0]  rd_o;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    idex_forward_if byp_if ();

    always #5 clk = ~clk;

    idex_forward dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .stall_i     (stall),
        .flush_i     (flush),
        .RS1data_i   (rs1d),
        .RS2data_i   (rs2d),
        .imm_i       (imm),
        .RS1addr_i   (rs1a),
        .RS2addr_i   (rs2a),
        .RDaddr_i    (rda),
        .ALUSrc_i    (alusrc),
        .ALUCtrl_i   (aluc),
        .RegWrite_i  (rw),
        .MemtoReg_i  (m2r),
        .MemRead_i   (mr),
        .MemWrite_i  (mw),
        .byp         (byp_if.slave),
        .data1_o     (data1),
        .data2_o     (data2),
        .ALUCtrl_o   (alu_o),
        .storedata_o (storedata),
        .RegWrite_o  (rw_o),
        .MemtoReg_o  (m2r_o),
        .MemRead_o   (mr_o),
        .MemWrite_o  (mw_o),
        .RDaddr_o    (rd_o),
        .hazard_o    (hazard)
    );

    function automatic id_t mk(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
                               input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                               input logic src, input logic [2:0] op, input logic [3:0] ctl);
        id_t v;
        v.rs1d = d1; v.rs2d = d2; v.imm = im;
        v.rs1a = a1; v.rs2a = a2; v.rda = rd;
        v.alusrc = src; v.alu = op; v.ctrl = ctl;
        return v;
    endfunction

    function automatic byp_t bp(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                                input logic ww, input logic [4:0] wr, input logic [31:0] wd);
        byp_t b;
        b.exw = ew; b.exrd = er; b.exd = ed;
        b.wbw = ww; b.wbrd = wr; b.wbd = wd;
        return b;
    endfunction

    function automatic exp_t ex(input string nm, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] sd, input logic [2:0] op, input logic [3:0] ctl,
                                input logic [4:0] rd, input logic hz);
        exp_t e;
        e.name = nm; e.d1 = d1; e.d2 = d2; e.sd = sd;
        e.alu = op; e.ctrl = ctl; e.rd = rd; e.hz = hz;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Drive one ID-stage vector ahead of the next rising edge and queue its expected outputs.
    task automatic step(input id_t v, input logic r, input logic s, input logic f,
                        input byp_t b, input exp_t e);
        @(negedge clk);
        rst = r; stall = s; flush = f;
        rs1d = v.rs1d; rs2d = v.rs2d; imm = v.imm;
        rs1a = v.rs1a; rs2a = v.rs2a; rda = v.rda;
        alusrc = v.alusrc; aluc = v.alu;
        {rw, m2r, mr, mw} = v.ctrl;
        byp_if.exmem_RegWrite = b.exw; byp_if.exmem_RDaddr = b.exrd; byp_if.exmem_data = b.exd;
        byp_if.memwb_RegWrite = b.wbw; byp_if.memwb_RDaddr = b.wbrd; byp_if.memwb_data = b.wbd;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".data1"}, data1, e.d1);
                chk({e.name, ".data2"}, data2, e.d2);
                chk({e.name, ".storedata"}, storedata, e.sd);
                chk({e.name, ".aluctrl"}, {29'd0, alu_o}, {29'd0, e.alu});
                chk({e.name, ".ctrl"}, {28'd0, rw_o, m2r_o, mr_o, mw_o}, {28'd0, e.ctrl});
                chk({e.name, ".rd"}, {27'd0, rd_o}, {27'd0, e.rd});
                chk({e.name, ".hazard"}, {31'd0, hazard}, {31'd0, e.hz});
            end
        end
    end

    initial begin : stimulus
        id_t  add1, ld5, dep5;
        byp_t none;
        none = bp(0, 0, 0, 0, 0, 0);
        add1 = mk(32'd5, 32'd7, 0, 5'd1, 5'd2, 5'd3, 0, 3'b010, 4'b1000);
        ld5  = mk(32'h1000, 0, 32'd4, 5'd1, 5'd0, 5'd5, 1, 3'b010, 4'b1110);
        dep5 = mk(32'd9, 32'd9, 0, 5'd5, 5'd2, 5'd6, 0, 3'b010, 4'b1000);
        rst = 1; stall = 0; flush = 0;
        rs1d = 0; rs2d = 0; imm = 0; rs1a = 0; rs2a = 0; rda = 0;
        alusrc = 0; aluc = 0; rw = 0; m2r = 0; mr = 0; mw = 0;
        byp_if.exmem_RegWrite = 0; byp_if.exmem_RDaddr = 0; byp_if.exmem_data = 0;
        byp_if.memwb_RegWrite = 0; byp_if.memwb_RDaddr = 0; byp_if.memwb_data = 0;

        step(add1, 1, 0, 0, none, ex("reset", 0, 0, 0, 3'b000, 4'b0000, 0, 0));
        step(add1, 0, 0, 0, none, ex("add", 5, 7, 7, 3'b010, 4'b1000, 3, 0));
        step(mk(32'h100, 32'h200, 0, 5'd4, 5'd6, 5'd7, 0, 3'b001, 4'b1000), 0, 0, 0,
             bp(1, 5'd4, 32'h11, 1, 5'd4, 32'h22),
             ex("fwd_exmem", 32'h11, 32'h200, 32'h200, 3'b001, 4'b1000, 7, 0));
        step(add1, 0, 1, 0, bp(0, 5'd4, 32'h11, 1, 5'd4, 32'h22),
             ex("fwd_memwb", 32'h22, 32'h200, 32'h200, 3'b001, 4'b1000, 7, 0));
        step(mk(32'd3, 0, 0, 5'd1, 5'd0, 5'd8, 0, 3'b010, 4'b1000), 0, 0, 0,
             bp(1, 5'd0, 32'hFF, 0, 0, 0),
             ex("x0_nofwd", 3, 0, 0, 3'b010, 4'b1000, 8, 0));
        step(mk(32'h40, 32'h1, 32'hFFFF_FFFC, 5'd2, 5'd9, 5'd0, 1, 3'b010, 4'b0001), 0, 0, 0,
             bp(1, 5'd10, 32'h77, 1, 5'd9, 32'h9),
             ex("store_imm", 32'h40, 32'hFFFF_FFFC, 32'h9, 3'b010, 4'b0001, 0, 0));
        step(ld5, 0, 0, 0, none, ex("lw_load", 32'h1000, 4, 0, 3'b010, 4'b1110, 5, 0));
        step(dep5, 0, 1, 0, none, ex("lw_hazard", 32'h1000, 4, 0, 3'b010, 4'b1110, 5, 1));
        step(dep5, 0, 0, 1, none, ex("flush", 0, 0, 0, 3'b000, 4'b0000, 0, 0));
        step(dep5, 0, 0, 0, bp(0, 0, 0, 1, 5'd5, 32'hABC),
             ex("after_flush", 32'hABC, 9, 9, 3'b010, 4'b1000, 6, 0));
        for (int i = 0; i < 3; i++)
            step(mk(32'd100 + i, 32'd200 + i, 32'd7 * i, 5'(20 + i), 5'(24 + i), 5'(28 + i),
                    1'(i & 1), 3'b101, 4'b1111), 0, 1, 0, none,
                 ex($sformatf("stall%0d", i), 9, 9, 9, 3'b010, 4'b1000, 6, 0));
        step(mk(32'd3, 32'd4, 0, 5'd10, 5'd11, 5'd12, 0, 3'b101, 4'b1000), 0, 0, 0, none,
             ex("mul", 3, 4, 4, 3'b101, 4'b1000, 12, 0));
        step(add1, 0, 1, 1, none, ex("stall_flush", 0, 0, 0, 3'b000, 4'b0000, 0, 0));
        step(mk(32'd20, 32'd6, 0, 5'd1, 5'd2, 5'd13, 0, 3'b110, 4'b1000), 0, 0, 0, none,
             ex("sub", 20, 6, 6, 3'b110, 4'b1000, 13, 0));
        step(add1, 1, 1, 0, bp(1, 5'd0, 32'hFF, 1, 5'd0, 32'hEE),
             ex("reset_stall", 0, 0, 0, 3'b000, 4'b0000, 0, 0));

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
